move_input: RTL

- Conditions the four raw direction buttons into the one-hot, single-cycle `move` strobe consumed by the player stage.
- Per-button processing: synchronise, debounce.
- Across buttons: arbitrate to a single direction, then emit one strobe per press plus optional auto-repeat while held.
- Sits between board I/O and `player`; runs on the same clock (div_res[1]).

---
 rtl/move_input_pkg.sv | 35 +++
 rtl/move_input_if.sv | 21 ++
 rtl/move_input_btn_debounce.sv | 50 +++++
 rtl/move_input.sv | 84 ++++++++
 4 files changed

// File: rtl/move_input_pkg.sv
// Shared definitions for the direction-input path: direction indices,
// FSM state encoding and small helpers for priority and one-hot encoding.
// Also imported by player_move so both sides agree on the bit map.
package move_input_pkg;

  localparam int NUM_DIR = 4;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } mi_state_e;

  // Lowest set index wins: up > down > left > right.
  function automatic logic [1:0] prio_dir(input logic [3:0] lvl);
    logic [1:0] d;
    d = DIR_UP;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (lvl[i]) d = 2'(i);
    end
    return d;
  endfunction

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    return oh;
  endfunction

endpackage

// File: rtl/move_input_if.sv
// Button-side and player-side signals of the move input conditioner.
// master drives the raw buttons and enable; slave is the conditioner itself.
// No handshake: move is a fire-and-forget single-cycle strobe.
interface move_input_if;
  logic [3:0] btn;
  logic       enable;
  logic [3:0] move;
  logic [3:0] btn_level;
  logic [1:0] active_dir;
  logic       held;

  modport master (
    output btn, enable,
    input  move, btn_level, active_dir, held
  );

  modport slave (
    input  btn, enable,
    output move, btn_level, active_dir, held
  );
endinterface

// File: rtl/move_input_btn_debounce.sv
// One-bit button conditioner: two-flop synchroniser plus stability counter.
// Latency: raw edge sampled at clock k shows on level_o after edge k+DEB_CYCLES+1.
// No backpressure; glitches shorter than DEB_CYCLES are swallowed.
module btn_debounce #(
  parameter int DEB_CYCLES = 20000,
  parameter int CNT_W      = 24
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser chain, debounced level and stability counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/move_input.sv
// Turns four raw direction buttons into a one-hot single-cycle move strobe with auto-repeat.
// Latency: raw press sampled at edge k gives move during cycle k+DEB_CYCLES+2.
// No backpressure; enable low suppresses strobes and drops any latched direction.
module move_input
  import move_input_pkg::*;
#(
  parameter int DEB_CYCLES    = 20000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int CNT_W         = 24
) (
  input logic          clk,
  input logic          rstn,
  move_input_if.slave  bus
);

  localparam bit               RPT_EN     = (REPEAT_DELAY != 0);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [3:0]       btn_lvl;
  mi_state_e        state_q;
  logic [1:0]       dir_q;
  logic [3:0]       move_q;
  logic [CNT_W-1:0] timer_q;

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk     (clk),
      .rstn    (rstn),
      .btn_i   (bus.btn[g]),
      .level_o (btn_lvl[g])
    );
  end

  // Arbitration, press/repeat FSM and repeat timer; move is registered and pulses one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      move_q  <= '0;
      timer_q <= '0;
    end else begin
      move_q <= '0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (bus.enable && (btn_lvl != 4'b0000)) begin
            dir_q   <= prio_dir(btn_lvl);
            move_q  <= dir_onehot(prio_dir(btn_lvl));
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          // Release (or disable) takes precedence over a due repeat.
          if (!btn_lvl[dir_q] || !bus.enable) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end else if (RPT_EN &&
                       (timer_q == ((state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST))) begin
            move_q  <= dir_onehot(dir_q);
            timer_q <= '0;
            state_q <= ST_REPEAT;
          end else if (RPT_EN) begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign bus.move       = move_q;
  assign bus.btn_level  = btn_lvl;
  assign bus.active_dir = dir_q;
  assign bus.held       = (state_q != ST_IDLE);

endmodule
